// File: rtl/cmp_pkg.sv
// Shared compare definitions: mode encodings and the single comparator used by every pipeline depth.
package cmp_pkg;

    localparam int unsigned CMP_MAXW = 64;

    typedef logic [2:0] cmp_mode_t;

    localparam cmp_mode_t MODE_EQ    = 3'd0;
    localparam cmp_mode_t MODE_NE    = 3'd1;
    localparam cmp_mode_t MODE_LT    = 3'd2;
    localparam cmp_mode_t MODE_GE    = 3'd3;
    localparam cmp_mode_t MODE_LTU   = 3'd4;
    localparam cmp_mode_t MODE_GEU   = 3'd5;
    localparam cmp_mode_t MODE_TRUE  = 3'd6;
    localparam cmp_mode_t MODE_FALSE = 3'd7;

    // Operands arrive MSB-aligned in CMP_MAXW bits (zeros below), so the borrow and
    // sign bits match those of a native WIDTH compare for any WIDTH <= CMP_MAXW.
    function automatic logic cmp_eval(input logic [CMP_MAXW-1:0] a,
                                      input logic [CMP_MAXW-1:0] b,
                                      input cmp_mode_t           mode);
        logic [CMP_MAXW:0] diff;
        logic              ltu;
        logic              lts;
        logic              eq;
        logic              res;
        diff = {1'b0, a} - {1'b0, b};
        ltu  = diff[CMP_MAXW];
        lts  = ltu ^ a[CMP_MAXW-1] ^ b[CMP_MAXW-1];
        eq   = (a == b);
        case (mode)
            MODE_EQ:   res = eq;
            MODE_NE:   res = ~eq;
            MODE_LT:   res = lts;
            MODE_GE:   res = ~lts;
            MODE_LTU:  res = ltu;
            MODE_GEU:  res = ~ltu;
            MODE_TRUE: res = 1'b1;
            default:   res = 1'b0;
        endcase
        return res;
    endfunction

endpackage

// File: rtl/cmp_stage.sv
// One valid/ready pipeline register slice with synchronous flush; payload reset is optional.
module cmp_stage
    import cmp_pkg::*;
#(
    parameter int unsigned W        = 1,
    parameter bit          RST_DATA = 1'b0
) (
    input  logic         clk_i,
    input  logic         rst_i,
    input  logic         flush_i,
    input  logic         valid_i,
    output logic         ready_o,
    input  logic [W-1:0] data_i,
    output logic         valid_o,
    input  logic         ready_i,
    output logic [W-1:0] data_o
);

    logic         valid_q;
    logic         valid_d;
    logic [W-1:0] data_q;
    logic [W-1:0] data_d;

    assign ready_o = ~valid_q | ready_i;
    assign valid_o = valid_q;
    assign data_o  = data_q;

    always_comb begin
        valid_d = valid_q;
        data_d  = data_q;
        if (ready_o) begin
            valid_d = valid_i;
            if (valid_i) data_d = data_i;
        end
        if (flush_i) valid_d = 1'b0;
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) valid_q <= 1'b0;
        else       valid_q <= valid_d;
        if (rst_i && RST_DATA) data_q <= '0;
        else                   data_q <= data_d;
    end

endmodule

// File: rtl/compare_pipe.sv
// Pipelined branch compare: operand slice (STAGES=2) then flag slice, valid/ready with flush.
module compare_pipe
    import cmp_pkg::*;
#(
    parameter int unsigned WIDTH  = 16,
    parameter int unsigned STAGES = 2
) (
    input  logic             CLK,
    input  logic             Reset,
    input  logic             Flush,
    input  logic             InValid,
    output logic             InReady,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    input  logic [2:0]       Mode,
    input  logic             ControlSignal,
    output logic             OutValid,
    input  logic             OutReady,
    output logic             Taken,
    output logic [WIDTH-1:0] R
);

    localparam int unsigned PAD = CMP_MAXW - WIDTH;

    generate
        if (STAGES == 2) begin : g_two
            localparam int unsigned PW = 2 * WIDTH + 4;

            logic [PW-1:0]    s1_data;
            logic             s1_valid;
            logic             s2_ready;
            logic [WIDTH-1:0] s1_a;
            logic [WIDTH-1:0] s1_b;
            logic [2:0]       s1_mode;
            logic             s1_cs;
            logic             flag;

            cmp_stage #(.W(PW), .RST_DATA(1'b0)) u_s1 (
                .clk_i   (CLK),
                .rst_i   (Reset),
                .flush_i (Flush),
                .valid_i (InValid),
                .ready_o (InReady),
                .data_i  ({A, B, Mode, ControlSignal}),
                .valid_o (s1_valid),
                .ready_i (s2_ready),
                .data_o  (s1_data)
            );

            assign {s1_a, s1_b, s1_mode, s1_cs} = s1_data;
            assign flag = cmp_eval(CMP_MAXW'(s1_a) << PAD, CMP_MAXW'(s1_b) << PAD, s1_mode) & s1_cs;

            cmp_stage #(.W(1), .RST_DATA(1'b1)) u_s2 (
                .clk_i   (CLK),
                .rst_i   (Reset),
                .flush_i (Flush),
                .valid_i (s1_valid),
                .ready_o (s2_ready),
                .data_i  (flag),
                .valid_o (OutValid),
                .ready_i (OutReady),
                .data_o  (Taken)
            );
        end else begin : g_one
            logic flag;

            assign flag = cmp_eval(CMP_MAXW'(A) << PAD, CMP_MAXW'(B) << PAD, Mode) & ControlSignal;

            cmp_stage #(.W(1), .RST_DATA(1'b1)) u_s1 (
                .clk_i   (CLK),
                .rst_i   (Reset),
                .flush_i (Flush),
                .valid_i (InValid),
                .ready_o (InReady),
                .data_i  (flag),
                .valid_o (OutValid),
                .ready_i (OutReady),
                .data_o  (Taken)
            );
        end
    endgenerate

    assign R = {{(WIDTH-1){1'b0}}, Taken};

endmodule

// File: tb/tb_compare_pipe.sv
// Bench for compare_pipe: WIDTH=16/STAGES=2 and WIDTH=32/STAGES=1 instances, one active at a time.
module tb_compare_pipe;
    import cmp_pkg::*;

    logic        clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst = 1'b1, flush = 1'b0, iv = 1'b0, ordy = 1'b1, cs = 1'b1, sel = 1'b0;
    logic [31:0] a = '0, b = '0;
    logic [2:0]  mode = '0;
    int          exp_lit = -1;

    logic        ir0, ov0, tk0, ir1, ov1, tk1;
    logic [15:0] r0;
    logic [31:0] r1;

    compare_pipe #(.WIDTH(16), .STAGES(2)) dut (
        .CLK(clk), .Reset(rst), .Flush(flush), .InValid(iv & ~sel), .InReady(ir0),
        .A(a[15:0]), .B(b[15:0]), .Mode(mode), .ControlSignal(cs),
        .OutValid(ov0), .OutReady(ordy), .Taken(tk0), .R(r0)
    );

    compare_pipe #(.WIDTH(32), .STAGES(1)) dut32 (
        .CLK(clk), .Reset(rst), .Flush(flush), .InValid(iv & sel), .InReady(ir1),
        .A(a), .B(b), .Mode(mode), .ControlSignal(cs),
        .OutValid(ov1), .OutReady(ordy), .Taken(tk1), .R(r1)
    );

    logic        d_ir, d_ov, d_tk;
    logic [31:0] d_r;
    assign d_ir = sel ? ir1 : ir0;
    assign d_ov = sel ? ov1 : ov0;
    assign d_tk = sel ? tk1 : tk0;
    assign d_r  = sel ? r1 : {16'h0, r0};

    // Model: queue of accepted ops, each with the earliest cycle it may be presented.
    typedef struct { bit flag; int rdy; int lit; } item_t;
    item_t mq[$];
    int    cyc = 0;
    bit    chk = 0, idle = 1;
    int    n_vec = 0, n_miss = 0;

    function automatic bit mflag(logic [31:0] xa, logic [31:0] xb, logic [2:0] m, logic c, int w);
        longint span, ua, ub, sa, sb;
        bit     f;
        span = longint'(1) << w;
        ua = longint'(xa) & (span - 1);
        ub = longint'(xb) & (span - 1);
        sa = (ua >= span / 2) ? ua - span : ua;
        sb = (ub >= span / 2) ? ub - span : ub;
        case (m)
            3'd0: f = (ua == ub);
            3'd1: f = (ua != ub);
            3'd2: f = (sa < sb);
            3'd3: f = (sa >= sb);
            3'd4: f = (ua < ub);
            3'd5: f = (ua >= ub);
            3'd6: f = 1'b1;
            default: f = 1'b0;
        endcase
        return f & c;
    endfunction

    function automatic bit m_ov(int c);
        return (mq.size() > 0) && (c >= mq[0].rdy);
    endfunction

    function automatic bit m_ir();
        return (mq.size() < (sel ? 1 : 2)) || ordy;
    endfunction

    always @(posedge clk) begin
        bit    ox, ix;
        item_t it;
        if (rst) begin
            mq.delete();
            idle = 1;
            chk  = 1;
        end else if (flush) begin
            mq.delete();
        end else begin
            ox = m_ov(cyc) && ordy;
            ix = iv && m_ir();
            if (ox) begin
                void'(mq.pop_front());
                if (mq.size() > 0 && mq[0].rdy < cyc + 1) mq[0].rdy = cyc + 1;
            end
            if (ix) begin
                it.flag = mflag(a, b, mode, cs, sel ? 32 : 16);
                it.rdy  = cyc + (sel ? 1 : 2);
                it.lit  = exp_lit;
                mq.push_back(it);
                idle = 0;
            end
        end
        cyc++;
    end

    task automatic chk1(input string nm, input logic [31:0] act, input logic [31:0] want);
        n_vec++;
        if (act !== want) begin
            n_miss++;
            $display("FAIL %s sel=%0d cyc=%0d got=%h want=%h", nm, sel, cyc, act, want);
        end
    endtask

    always @(negedge clk) begin
        bit v;
        if (chk) begin
            v = m_ov(cyc);
            chk1("OutValid", {31'b0, d_ov}, {31'b0, v});
            chk1("InReady", {31'b0, d_ir}, {31'b0, m_ir()});
            if (v) begin
                chk1("Taken", {31'b0, d_tk}, {31'b0, mq[0].flag});
                chk1("R", d_r, {31'b0, mq[0].flag});
                if (mq[0].lit >= 0) chk1("Taken_literal", {31'b0, d_tk}, {31'b0, mq[0].lit[0]});
            end else if (idle) begin
                chk1("Taken_idle", {31'b0, d_tk}, 32'h0);
                chk1("R_idle", d_r, 32'h0);
            end
        end
    end

    task automatic send(input logic [31:0] xa, input logic [31:0] xb, input logic [2:0] xm,
                        input logic xc, input int lit);
        bit acc = 0;
        a = xa; b = xb; mode = xm; cs = xc; exp_lit = lit; iv = 1'b1;
        for (int k = 0; k < 40 && !acc; k++) begin
            @(negedge clk);
            acc = d_ir;
            @(posedge clk);
            #1;
        end
        iv = 1'b0;
        n_vec++;
        if (!acc) begin
            n_miss++;
            $display("FAIL send_timeout sel=%0d a=%h b=%h got=no_accept want=accept", sel, xa, xb);
        end
    endtask

    task automatic idle_cycles(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic run_suite();
        logic [31:0] msb;
        logic [7:0]  sweep_exp;
        msb = sel ? 32'h8000_0000 : 32'h0000_8000;
        // a=5 against a negative b, modes 0..7: EQ NE LT GE LTU GEU TRUE FALSE
        sweep_exp = 8'b0101_1010;

        rst = 1'b1; ordy = 1'b1;
        idle_cycles(2);
        rst = 1'b0;
        idle_cycles(3);

        send(msb, msb - 1, MODE_LT, 1'b1, 1);
        send(msb, msb - 1, MODE_LTU, 1'b1, 0);
        send(32'h1234, 32'h1234, MODE_EQ, 1'b0, 0);
        send(msb, 32'h1, MODE_GE, 1'b1, 0);
        for (int m = 0; m < 8; m++) send(32'h5, msb | 32'h5, 3'(m), 1'b1, int'(sweep_exp[m]));
        idle_cycles(4);

        for (int i = 0; i < 8; i++) send(32'(i), 32'h3, MODE_EQ, 1'b1, (i == 3) ? 1 : 0);
        idle_cycles(4);

        ordy = 1'b0;
        fork
            begin
                send(32'h1, 32'h2, MODE_LTU, 1'b1, 1);
                send(32'h2, 32'h1, MODE_LTU, 1'b1, 0);
                send(32'h7, 32'h7, MODE_GEU, 1'b1, 1);
            end
            begin
                repeat (5) @(posedge clk);
                #1 ordy = 1'b1;
            end
        join
        idle_cycles(4);

        ordy = 1'b0;
        for (int i = 0; i < (sel ? 1 : 2); i++) send(32'(i), 32'h0, MODE_EQ, 1'b1, (i == 0) ? 1 : 0);
        idle_cycles(2);
        flush = 1'b1; iv = 1'b1;
        a = 32'h9; b = 32'h9; mode = MODE_EQ; cs = 1'b1; exp_lit = 1;
        idle_cycles(1);
        flush = 1'b0; iv = 1'b0; ordy = 1'b1;
        send(32'h3, 32'h4, MODE_NE, 1'b1, 1);
        idle_cycles(4);

        fork
            for (int i = 0; i < 6; i++) send(32'(i), 32'h2, MODE_LTU, 1'b1, (i < 2) ? 1 : 0);
            begin
                repeat (3) @(posedge clk);
                #1 rst = 1'b1;
                @(posedge clk);
                #1 rst = 1'b0;
            end
        join
        idle_cycles(5);
    endtask

    initial begin
        sel = 1'b0;
        run_suite();
        rst = 1'b1;
        idle_cycles(1);
        sel = 1'b1;
        run_suite();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule
